string_sched: RTL

STRING_SCHED -- requirements
Module: string_sched

---
 rtl/string_pkg.sv | 18 +
 rtl/rr_arb2.sv | 35 +++
 rtl/string_sched.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/string_pkg.sv
// Shared definitions for the string scheduler: FSM state encoding,
// default frame length / stall limit, and the checker byte width.
package string_pkg;

    localparam int BYTE_W      = 8;
    localparam int MAX_LEN_DEF = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_REPORT = 3'd5;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. Remembers the last served requester
// and, on contention, picks the other one. After reset requester 0 wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic       gnt_id
);

    logic last_q;

    // Pick the requester; on contention favour the one not served last.
    always_comb begin
        // NOTE: default first so every path assigns gnt_id and no latch is inferred.
        gnt_id = 1'b0;
        if (req[0] && req[1]) begin
            gnt_id = ~last_q;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
    end

    // Record who was served once their result is reported.
    always_ff @(posedge clk) begin
        if (clr) begin
            // NOTE: non-blocking assignment for all clocked state to avoid ordering races.
            last_q <= 1'b1;
        end else if (upd) begin
            last_q <= upd_id;
        end
    end

endmodule

// File: rtl/string_sched.sv
// Two-requester scheduler for a shared string checker. One frame at a time
// is granted, streamed into the checker (truncated at MAX_LEN, remainder
// drained), and its match result reported with a one-cycle strobe.
// Optional stall timeout: define STRING_SCHED_TIMEOUT_EN.
module string_sched
    import string_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req0_valid,
    input  logic [BYTE_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [BYTE_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              chk_clr,
    output logic [BYTE_W-1:0] chk_in,
    output logic              chk_en,
    input  logic              chk_out,
    output logic              res_valid,
    output logic              res_id,
    output logic              res_match,
    output logic              res_ovf
);

    if (MAX_LEN < 2 || MAX_LEN > 255 || TIMEOUT < 1) begin : g_param_check
        $error("string_sched: MAX_LEN must be 2..255 and TIMEOUT >= 1");
    end

    state_t            state_q, state_d;
    logic              grant_q;
    logic [7:0]        cnt_q;
    logic              ovf_q, match_q, to_q;
    logic              arb_id;
    logic              g_valid, g_last;
    logic [BYTE_W-1:0] g_data;
    logic              busy, accept, at_max, stall_hit;

    rr_arb2 u_arb (
        .clk    (clk),
        .clr    (clr),
        .req    ({req1_valid, req0_valid}),
        .upd    (state_q == ST_REPORT),
        .upd_id (grant_q),
        .gnt_id (arb_id)
    );

    // Select the granted requester's byte stream.
    always_comb begin
        g_valid = grant_q ? req1_valid : req0_valid;
        g_data  = grant_q ? req1_data  : req0_data;
        g_last  = grant_q ? req1_last  : req0_last;
    end

    assign busy   = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    assign accept = busy && g_valid;
    assign at_max = (cnt_q == 8'(MAX_LEN - 1));

`ifdef STRING_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] stall_q;

    assign stall_hit = busy && !g_valid && (stall_q == TO_W'(TIMEOUT - 1));

    // Count consecutive cycles the granted requester leaves the bus idle.
    always_ff @(posedge clk) begin
        if (clr || !busy || g_valid) begin
            stall_q <= '0;
        end else if (!stall_hit) begin
            stall_q <= stall_q + 1'b1;
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req0_valid || req1_valid) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = ST_STREAM;
            ST_STREAM: begin
                if (accept) begin
                    if (g_last)      state_d = ST_WAIT;
                    else if (at_max) state_d = ST_DRAIN;
                end else if (stall_hit) begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN:  if ((accept && g_last) || stall_hit) state_d = ST_WAIT;
            ST_WAIT:   state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sequencer state, grant, byte counter and result registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            match_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req0_valid || req1_valid) grant_q <= arb_id;
                end
                ST_CLEAR: begin
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                    to_q  <= 1'b0;
                end
                ST_STREAM: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 8'd1;
                        ovf_q <= !g_last && at_max;
                    end else if (stall_hit) begin
                        ovf_q <= 1'b1;
                        to_q  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!accept && stall_hit) begin
                        to_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    match_q <= chk_out && !to_q;
                end
                default: ;
            endcase
        end
    end

    assign req0_ready = busy && !grant_q;
    assign req1_ready = busy &&  grant_q;
    assign chk_clr    = (state_q == ST_CLEAR);
    assign chk_en     = accept && (state_q == ST_STREAM);
    assign chk_in     = chk_en ? g_data : '0;
    assign res_valid  = (state_q == ST_REPORT);
    assign res_id     = res_valid && grant_q;
    assign res_match  = res_valid && match_q;
    assign res_ovf    = res_valid && ovf_q;

endmodule
